// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by the crossbar, sockets and adapters.
// Provides the field widths, opcode enums and the host-to-device /
// device-to-host channel bundles tl_h2d_t and tl_d2h_t.
package tlul_pkg;

  localparam int TL_AW  = 32;          // address width
  localparam int TL_DW  = 32;          // data width
  localparam int TL_AIW = 8;           // A-channel source id width
  localparam int TL_DIW = 1;           // D-channel sink id width
  localparam int TL_SZW = 2;           // log2 size field width
  localparam int TL_DBW = TL_DW / 8;   // byte-mask width
  localparam int TL_AUW = 16;          // A-channel user width
  localparam int TL_DUW = 16;          // D-channel user width

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                  a_valid;
    tl_a_op_e              a_opcode;
    logic [2:0]            a_param;
    logic [TL_SZW-1:0]     a_size;
    logic [TL_AIW-1:0]     a_source;
    logic [TL_AW-1:0]      a_address;
    logic [TL_DBW-1:0]     a_mask;
    logic [TL_DW-1:0]      a_data;
    logic [TL_AUW-1:0]     a_user;
    logic                  d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                  d_valid;
    tl_d_op_e              d_opcode;
    logic [2:0]            d_param;
    logic [TL_SZW-1:0]     d_size;
    logic [TL_AIW-1:0]     d_source;
    logic [TL_DIW-1:0]     d_sink;
    logic [TL_DW-1:0]      d_data;
    logic [TL_DUW-1:0]     d_user;
    logic                  d_error;
    logic                  a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/fifo_sync.sv
// Generic synchronous FIFO with a registered occupancy count.
// wready/rvalid depend only on the count register, so there is no
// combinational path from the write side to the read side or back.
// No bypass: a pushed entry becomes visible on the next cycle.
// Ports:
//   clk_i, rst_i        clock, async active-high reset (clears storage too)
//   wvalid/wready/wdata write handshake and payload
//   rvalid/rready/rdata read handshake and head-of-queue payload
//   cnt                 current occupancy, 0..Depth
module fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [Width-1:0]           wdata,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [Width-1:0]           rdata,
  output logic [$clog2(Depth+1)-1:0] cnt
);

  // Depth=1 still needs a 1-bit pointer so the index has a width.
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Depth-1:0][Width-1:0] mem;
  logic [PtrW-1:0]             wr_ptr, rd_ptr;
  logic [CntW-1:0]             cnt_q;
  logic                        full, empty, push, pop;

  // Pointers wrap at Depth-1, so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (cnt_q == CntW'(Depth));
  assign empty  = (cnt_q == '0);
  assign wready = ~full;
  assign rvalid = ~empty;
  assign push   = wvalid & wready;
  assign pop    = rvalid & rready;
  assign rdata  = mem[rd_ptr];
  assign cnt    = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/tlul_fifo_buf.sv
// Registered TL-UL buffer stage: one FIFO per channel decouples the
// host-side and device-side ports. Payloads pass through untouched and
// in order; all valid/ready outputs come from FIFO count registers.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   tl_h_i/tl_h_o host-side request in / response + a_ready out
//   tl_d_o/tl_d_i device-side request + d_ready out / response in
//   req_cnt_o     A-channel FIFO occupancy
//   rsp_cnt_o     D-channel FIFO occupancy
module tlul_fifo_buf
  import tlul_pkg::*;
#(
  parameter int ReqDepth = 2,
  parameter int RspDepth = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  tl_h2d_t                       tl_h_i,
  output tl_d2h_t                       tl_h_o,
  output tl_h2d_t                       tl_d_o,
  input  tl_d2h_t                       tl_d_i,
  output logic [$clog2(ReqDepth+1)-1:0] req_cnt_o,
  output logic [$clog2(RspDepth+1)-1:0] rsp_cnt_o
);

  // Stored payloads: everything except the handshake bits.
  typedef struct packed {
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
  } req_t;

  typedef struct packed {
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
  } rsp_t;

  req_t req_wdata, req_rdata;
  rsp_t rsp_wdata, rsp_rdata;
  logic req_wready, req_rvalid, rsp_wready, rsp_rvalid;

  assign req_wdata = '{
    a_opcode:  tl_h_i.a_opcode,
    a_param:   tl_h_i.a_param,
    a_size:    tl_h_i.a_size,
    a_source:  tl_h_i.a_source,
    a_address: tl_h_i.a_address,
    a_mask:    tl_h_i.a_mask,
    a_data:    tl_h_i.a_data,
    a_user:    tl_h_i.a_user
  };

  assign rsp_wdata = '{
    d_opcode: tl_d_i.d_opcode,
    d_param:  tl_d_i.d_param,
    d_size:   tl_d_i.d_size,
    d_source: tl_d_i.d_source,
    d_sink:   tl_d_i.d_sink,
    d_data:   tl_d_i.d_data,
    d_user:   tl_d_i.d_user,
    d_error:  tl_d_i.d_error
  };

  fifo_sync #(
    .Width ($bits(req_t)),
    .Depth (ReqDepth)
  ) u_req_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wvalid (tl_h_i.a_valid),
    .wready (req_wready),
    .wdata  (req_wdata),
    .rvalid (req_rvalid),
    .rready (tl_d_i.a_ready),
    .rdata  (req_rdata),
    .cnt    (req_cnt_o)
  );

  fifo_sync #(
    .Width ($bits(rsp_t)),
    .Depth (RspDepth)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wvalid (tl_d_i.d_valid),
    .wready (rsp_wready),
    .wdata  (rsp_wdata),
    .rvalid (rsp_rvalid),
    .rready (tl_h_i.d_ready),
    .rdata  (rsp_rdata),
    .cnt    (rsp_cnt_o)
  );

  always_comb begin
    tl_d_o           = '0;
    tl_d_o.a_valid   = req_rvalid;
    tl_d_o.a_opcode  = req_rdata.a_opcode;
    tl_d_o.a_param   = req_rdata.a_param;
    tl_d_o.a_size    = req_rdata.a_size;
    tl_d_o.a_source  = req_rdata.a_source;
    tl_d_o.a_address = req_rdata.a_address;
    tl_d_o.a_mask    = req_rdata.a_mask;
    tl_d_o.a_data    = req_rdata.a_data;
    tl_d_o.a_user    = req_rdata.a_user;
    tl_d_o.d_ready   = rsp_wready;
  end

  always_comb begin
    tl_h_o          = '0;
    tl_h_o.d_valid  = rsp_rvalid;
    tl_h_o.d_opcode = rsp_rdata.d_opcode;
    tl_h_o.d_param  = rsp_rdata.d_param;
    tl_h_o.d_size   = rsp_rdata.d_size;
    tl_h_o.d_source = rsp_rdata.d_source;
    tl_h_o.d_sink   = rsp_rdata.d_sink;
    tl_h_o.d_data   = rsp_rdata.d_data;
    tl_h_o.d_user   = rsp_rdata.d_user;
    tl_h_o.d_error  = rsp_rdata.d_error;
    tl_h_o.a_ready  = req_wready;
  end

endmodule

// File: tb/tb_tlul_fifo_buf.sv
// Directed bench: dut0 uses 2/2 depths, dut1 uses 1/3 depths.
// Inputs are driven and outputs sampled on the falling edge.
module tb_tlul_fifo_buf;
  import tlul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tl_h2d_t h_i0, d_o0, h_i1, d_o1;
  tl_d2h_t h_o0, d_i0, h_o1, d_i1;
  logic [1:0] req_cnt0, rsp_cnt0, rsp_cnt1;
  logic       req_cnt1;

  tlul_fifo_buf #(.ReqDepth(2), .RspDepth(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .tl_h_i(h_i0), .tl_h_o(h_o0),
    .tl_d_o(d_o0), .tl_d_i(d_i0), .req_cnt_o(req_cnt0), .rsp_cnt_o(rsp_cnt0)
  );

  tlul_fifo_buf #(.ReqDepth(1), .RspDepth(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .tl_h_i(h_i1), .tl_h_o(h_o1),
    .tl_d_o(d_o1), .tl_d_i(d_i1), .req_cnt_o(req_cnt1), .rsp_cnt_o(rsp_cnt1)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    int tx, rx;
    logic acc, pop;

    rst  = 1'b1;
    h_i0 = '0; d_i0 = '0; h_i1 = '0; d_i1 = '0;

    // ---- reset state ----
    @(negedge clk);
    chk("rst_a_ready",  h_o0.a_ready, 1);
    chk("rst_d_ready",  d_o0.d_ready, 1);
    chk("rst_a_valid",  d_o0.a_valid, 0);
    chk("rst_d_valid",  h_o0.d_valid, 0);
    chk("rst_req_cnt",  req_cnt0, 0);
    chk("rst_rsp_cnt",  rsp_cnt0, 0);
    chk("rst_a_addr",   d_o0.a_address, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_a_ready", h_o0.a_ready, 1);
    chk("idle_a_valid", d_o0.a_valid, 0);
    chk("idle1_a_ready", h_o1.a_ready, 1);
    chk("idle1_d_ready", d_o1.d_ready, 1);

    // ---- single Get pass-through ----
    d_i0.a_ready    = 1'b1;
    h_i0.a_valid    = 1'b1;
    h_i0.a_opcode   = Get;
    h_i0.a_address  = 32'h10;
    h_i0.a_source   = 8'd3;
    h_i0.a_mask     = 4'hf;
    #1 chk("get_no_bypass", d_o0.a_valid, 0);
    @(negedge clk);
    h_i0.a_valid = 1'b0;
    chk("get_a_valid",  d_o0.a_valid, 1);
    chk("get_addr",     d_o0.a_address, 32'h10);
    chk("get_source",   d_o0.a_source, 3);
    chk("get_opcode",   d_o0.a_opcode, Get);
    chk("get_req_cnt",  req_cnt0, 1);
    @(negedge clk);
    chk("get_drained",  d_o0.a_valid, 0);
    h_i0.d_ready    = 1'b1;
    d_i0.d_valid    = 1'b1;
    d_i0.d_opcode   = AccessAckData;
    d_i0.d_source   = 8'd3;
    d_i0.d_data     = 32'hDEADBEEF;
    @(negedge clk);
    d_i0.d_valid = 1'b0;
    chk("ack_d_valid",  h_o0.d_valid, 1);
    chk("ack_data",     h_o0.d_data, 32'hDEADBEEF);
    chk("ack_opcode",   h_o0.d_opcode, AccessAckData);
    chk("ack_source",   h_o0.d_source, 3);
    @(negedge clk);
    chk("ack_drained",  h_o0.d_valid, 0);

    // ---- backpressure fill: 3 PutFullData, device stalled 4 cycles ----
    h_i0.a_opcode = PutFullData;
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 40 && rx < 3; cyc++) begin
      d_i0.a_ready = (cyc >= 4);
      h_i0.a_valid = (tx < 3);
      h_i0.a_data  = (tx < 3) ? 32'(tx + 1) : 32'h0;
      if (cyc == 2) begin
        chk("bp_req_cnt", req_cnt0, 2);
        chk("bp_a_ready", h_o0.a_ready, 0);
      end
      acc = h_i0.a_valid & h_o0.a_ready;
      pop = d_o0.a_valid & d_i0.a_ready;
      if (pop) chk("bp_data", d_o0.a_data, 64'(rx + 1));
      @(posedge clk);
      if (acc) tx++;
      if (pop) rx++;
      @(negedge clk);
    end
    h_i0.a_valid = 1'b0;
    chk("bp_rx_count", rx, 3);
    chk("bp_ready_back", h_o0.a_ready, 1);
    chk("bp_cnt_zero", req_cnt0, 0);

    // ---- D-FIFO held at count 1 with push and pop every cycle ----
    h_i0.d_ready  = 1'b0;
    d_i0.d_valid  = 1'b1;
    d_i0.d_opcode = AccessAck;
    d_i0.d_data   = 32'd100;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      h_i0.d_ready = 1'b1;
      d_i0.d_data  = 32'(101 + k);
      chk("sim_cnt",   rsp_cnt0, 1);
      chk("sim_data",  h_o0.d_data, 64'(100 + k));
      chk("sim_ready", d_o0.d_ready, 1);
      @(negedge clk);
    end
    d_i0.d_valid = 1'b0;
    chk("sim_last",  h_o0.d_data, 110);
    chk("sim_cnt_l", rsp_cnt0, 1);
    @(negedge clk);
    chk("sim_empty", rsp_cnt0, 0);
    h_i0.d_ready = 1'b0;

    // ---- ReqDepth=1: one transfer every two cycles ----
    d_i1.a_ready  = 1'b1;
    h_i1.a_opcode = PutFullData;
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 40 && rx < 7; cyc++) begin
      h_i1.a_valid = (tx < 7);
      h_i1.a_data  = 32'h100 + 32'(tx);
      chk("d1_a_ready", h_o1.a_ready, 64'(cyc % 2 == 0));
      chk("d1_a_valid", d_o1.a_valid, 64'(cyc % 2 == 1));
      acc = h_i1.a_valid & h_o1.a_ready;
      pop = d_o1.a_valid & d_i1.a_ready;
      if (pop) chk("d1_a_data", d_o1.a_data, 64'(32'h100 + 32'(rx)));
      @(posedge clk);
      if (acc) tx++;
      if (pop) rx++;
      @(negedge clk);
    end
    h_i1.a_valid = 1'b0;
    chk("d1_rx_count", rx, 7);

    // ---- RspDepth=3: fill, then stream so pointers wrap ----
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 40 && rx < 7; cyc++) begin
      h_i1.d_ready = (cyc >= 3);
      d_i1.d_valid = (tx < 7);
      d_i1.d_data  = 32'h200 + 32'(tx);
      if (cyc == 3) begin
        chk("d3_full_cnt", rsp_cnt1, 3);
        chk("d3_d_ready",  d_o1.d_ready, 0);
      end
      acc = d_i1.d_valid & d_o1.d_ready;
      pop = h_o1.d_valid & h_i1.d_ready;
      if (pop) chk("d3_data", h_o1.d_data, 64'(32'h200 + 32'(rx)));
      @(posedge clk);
      if (acc) tx++;
      if (pop) rx++;
      @(negedge clk);
    end
    d_i1.d_valid = 1'b0;
    chk("d3_rx_count", rx, 7);
    chk("d3_empty", rsp_cnt1, 0);

    // ---- mid-operation asynchronous reset with 2 entries per FIFO ----
    d_i0.a_ready = 1'b0;
    h_i0.d_ready = 1'b0;
    h_i0.a_valid = 1'b1; h_i0.a_data = 32'h55;
    d_i0.d_valid = 1'b1; d_i0.d_data = 32'h66;
    repeat (2) @(negedge clk);
    h_i0.a_valid = 1'b0;
    d_i0.d_valid = 1'b0;
    chk("mr_req_cnt2", req_cnt0, 2);
    chk("mr_rsp_cnt2", rsp_cnt0, 2);
    #2 rst = 1'b1;
    #1;
    chk("mr_req_cnt0", req_cnt0, 0);
    chk("mr_rsp_cnt0", rsp_cnt0, 0);
    chk("mr_a_valid",  d_o0.a_valid, 0);
    chk("mr_d_valid",  h_o0.d_valid, 0);
    chk("mr_a_data",   d_o0.a_data, 0);
    chk("mr_a_ready",  h_o0.a_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    d_i0.a_ready = 1'b1;
    h_i0.d_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mr_no_stale_a", d_o0.a_valid, 0);
      chk("mr_no_stale_d", h_o0.d_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
